// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: MEM-stage state encoding and
// bit positions of the WB and M control fields carried in EX/MEM.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // WB control field bit positions
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  // M control field bit positions
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  // Word accesses only: the two low address bits must be zero.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: four fields updated together under a load enable.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [1:0]  wb_in,
  input  logic [31:0] read_data_in,
  input  logic [31:0] alu_result_in,
  input  logic [4:0]  write_register_in,
  output logic [1:0]  wb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_register_out
);

  logic [1:0]  wb_q, wb_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  write_register_q, write_register_d;

  // Next value: take the new fields when loading, otherwise hold.
  always_comb begin
    wb_d             = wb_q;
    read_data_d      = read_data_q;
    alu_result_d     = alu_result_q;
    write_register_d = write_register_q;
    if (load) begin
      wb_d             = wb_in;
      read_data_d      = read_data_in;
      alu_result_d     = alu_result_in;
      write_register_d = write_register_in;
    end
  end

  // Register bank, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q             <= 2'b00;
      read_data_q      <= 32'd0;
      alu_result_q     <= 32'd0;
      write_register_q <= 5'd0;
    end else begin
      wb_q             <= wb_d;
      read_data_q      <= read_data_d;
      alu_result_q     <= alu_result_d;
      write_register_q <= write_register_d;
    end
  end

  assign wb_out             = wb_q;
  assign read_data_out      = read_data_q;
  assign alu_result_out     = alu_result_q;
  assign write_register_out = write_register_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: resolves branches, runs loads/stores over a req/ready data bus,
// stalls upstream while an access is outstanding and feeds MEM/WB.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  WB,
  input  logic [2:0]  M,
  input  logic [31:0] PC,
  input  logic        zero,
  input  logic [31:0] ALUresult,
  input  logic [31:0] writeData,
  input  logic [4:0]  writeRegister,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] branch_target,
  output logic [1:0]  WB_output,
  output logic [31:0] readData_output,
  output logic [31:0] ALUresult_output,
  output logic [4:0]  writeRegister_output,
  output logic        misalign_err,
  output logic        bus_err
);

  // Last WAIT cycle index before the access is abandoned.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        misalign_err_q, misalign_err_d;
  logic        bus_err_q, bus_err_d;

  logic        mem_op;
  logic        is_write;
  logic        aligned;

  logic        wb_load;
  logic [1:0]  wb_in;
  logic [31:0] read_data_in;

  // Both MemRead and MemWrite set is treated as a write.
  assign mem_op   = M[MEMREAD] | M[MEMWRITE];
  assign is_write = M[MEMWRITE];
  assign aligned  = is_word_aligned(ALUresult);

  // Next-state, bus, MEM/WB load and stall decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    abort_d        = abort_q;
    rdata_d        = rdata_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    misalign_err_d = 1'b0;
    bus_err_d      = 1'b0;
    stall          = 1'b0;
    wb_load        = 1'b0;
    wb_in          = WB;
    read_data_in   = 32'd0;

    case (state_q)
      IDLE: begin
        if (mem_op && aligned) begin
          // Issue: latch the bus fields and start the timeout count.
          stall       = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = is_write;
          mem_addr_d  = ALUresult;
          mem_wdata_d = writeData;
          cnt_d       = 8'd0;
          abort_d     = 1'b0;
          state_d     = WAIT;
        end else if (mem_op) begin
          // Misaligned: never touches the bus, writeback squashed.
          wb_load        = 1'b1;
          wb_in          = 2'b00;
          misalign_err_d = 1'b1;
        end else begin
          wb_load = 1'b1;
        end
      end

      WAIT: begin
        stall = 1'b1;
        if (mem_ready) begin
          // Ready has priority over the timeout on the same cycle.
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == LAST_WAIT) begin
          mem_req_d = 1'b0;
          abort_d   = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        // Retire without re-issuing; upstream advances at this edge.
        wb_load = 1'b1;
        if (abort_q) begin
          wb_in     = 2'b00;
          bus_err_d = 1'b1;
        end else if (!mem_we_q) begin
          read_data_in = rdata_q;
        end
        abort_d = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage control and bus registers; reset drops mem_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      abort_q        <= 1'b0;
      rdata_q        <= 32'd0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_wdata_q    <= 32'd0;
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      abort_q        <= abort_d;
      rdata_q        <= rdata_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      misalign_err_q <= misalign_err_d;
      bus_err_q      <= bus_err_d;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk                (clk),
    .rst_n              (rst_n),
    .load               (wb_load),
    .wb_in              (wb_in),
    .read_data_in       (read_data_in),
    .alu_result_in      (ALUresult),
    .write_register_in  (writeRegister),
    .wb_out             (WB_output),
    .read_data_out      (readData_output),
    .alu_result_out     (ALUresult_output),
    .write_register_out (writeRegister_output)
  );

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign misalign_err  = misalign_err_q;
  assign bus_err       = bus_err_q;
  assign PCSrc         = M[BRANCH] & zero & ~stall;
  assign branch_target = PC;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=4.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [31:0] PC;
  logic        zero;
  logic [31:0] ALUresult;
  logic [31:0] writeData;
  logic [4:0]  writeRegister;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic [1:0]  WB_output;
  logic [31:0] readData_output;
  logic [31:0] ALUresult_output;
  logic [4:0]  writeRegister_output;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .WB                   (WB),
    .M                    (M),
    .PC                   (PC),
    .zero                 (zero),
    .ALUresult            (ALUresult),
    .writeData            (writeData),
    .writeRegister        (writeRegister),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_ready            (mem_ready),
    .stall                (stall),
    .PCSrc                (PCSrc),
    .branch_target        (branch_target),
    .WB_output            (WB_output),
    .readData_output      (readData_output),
    .ALUresult_output     (ALUresult_output),
    .writeRegister_output (writeRegister_output),
    .misalign_err         (misalign_err),
    .bus_err              (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] wb, input logic [2:0] m,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] wr);
    WB = wb; M = m; ALUresult = alu; writeData = wd; writeRegister = wr;
  endtask

  task automatic nop();
    set_instr(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0; PC = 32'h0; zero = 1'b0; mem_rdata = 32'h0; mem_ready = 1'b0;
    nop();
    #3;
    // Reset state
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wb", WB_output, 0);
    chk("rst_rd", readData_output, 0);
    chk("rst_alu", ALUresult_output, 0);
    chk("rst_wr", writeRegister_output, 0);
    chk("rst_mis", misalign_err, 0);
    chk("rst_berr", bus_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    $display("step reset released");

    // R-type
    set_instr(2'b10, 3'b000, 32'h1234, 32'h0, 5'd5);
    #1 chk("rtype_stall", stall, 0);
    tick();
    chk("rtype_wb", WB_output, 2'b10);
    chk("rtype_alu", ALUresult_output, 32'h1234);
    chk("rtype_wr", writeRegister_output, 5);
    chk("rtype_rd", readData_output, 0);
    chk("rtype_req", mem_req, 0);
    $display("step rtype done");

    // Branch taken / not taken
    set_instr(2'b00, 3'b100, 32'h0, 32'h0, 5'd0);
    PC = 32'h40; zero = 1'b1;
    #1 chk("br_pcsrc", PCSrc, 1);
    chk("br_target", branch_target, 32'h40);
    zero = 1'b0;
    #1 chk("br_nottaken", PCSrc, 0);
    tick();
    $display("step branch done");

    // Load at 0x100, ready in 3rd WAIT cycle
    set_instr(2'b11, 3'b010, 32'h100, 32'h0, 5'd7);
    PC = 32'h0;
    #1 chk("ld_issue_stall", stall, 1);
    tick();
    chk("ld_w1_req", mem_req, 1);
    chk("ld_w1_we", mem_we, 0);
    chk("ld_w1_addr", mem_addr, 32'h100);
    chk("ld_w1_stall", stall, 1);
    tick();
    chk("ld_w2_req", mem_req, 1);
    chk("ld_w2_stall", stall, 1);
    tick();
    chk("ld_w3_req", mem_req, 1);
    chk("ld_w3_stall", stall, 1);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    chk("ld_done_req", mem_req, 0);
    chk("ld_done_stall", stall, 0);
    tick();
    nop();
    chk("ld_wb", WB_output, 2'b11);
    chk("ld_rd", readData_output, 32'hDEADBEEF);
    chk("ld_alu", ALUresult_output, 32'h100);
    chk("ld_wr", writeRegister_output, 7);
    chk("ld_req_after", mem_req, 0);
    $display("step load 0x100 done");

    // Store at 0x104, immediate ready; ready in IDLE first must be ignored
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("idle_ready_ignored", mem_req, 0);
    set_instr(2'b00, 3'b001, 32'h104, 32'hCAFE, 5'd0);
    tick();
    chk("st_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 32'hCAFE);
    chk("st_addr", mem_addr, 32'h104);
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ready = 1'b0;
    chk("st_done_stall", stall, 0);
    tick();
    nop();
    chk("st_rd", readData_output, 0);
    chk("st_wb", WB_output, 0);
    $display("step store 0x104 done");

    // Misaligned load
    set_instr(2'b11, 3'b010, 32'h102, 32'h0, 5'd9);
    #1 chk("mis_stall", stall, 0);
    tick();
    nop();
    chk("mis_req", mem_req, 0);
    chk("mis_pulse", misalign_err, 1);
    chk("mis_wb", WB_output, 0);
    chk("mis_alu", ALUresult_output, 32'h102);
    tick();
    chk("mis_pulse_end", misalign_err, 0);
    $display("step misaligned done");

    // Timeout: ready never comes
    set_instr(2'b11, 3'b010, 32'h200, 32'h0, 5'd3);
    #1 chk("to_issue_stall", stall, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("to_w%0d_req", i), mem_req, 1);
      chk($sformatf("to_w%0d_stall", i), stall, 1);
    end
    tick();
    chk("to_done_req", mem_req, 0);
    chk("to_done_stall", stall, 0);
    chk("to_done_berr", bus_err, 0);
    tick();
    nop();
    chk("to_berr", bus_err, 1);
    chk("to_wb", WB_output, 0);
    chk("to_rd", readData_output, 0);
    tick();
    chk("to_berr_end", bus_err, 0);
    $display("step timeout done");

    // Ready on the last WAIT cycle wins over timeout
    set_instr(2'b11, 3'b010, 32'h300, 32'h0, 5'd4);
    tick(); tick(); tick(); tick();
    chk("edge_w4_req", mem_req, 1);
    mem_ready = 1'b1; mem_rdata = 32'h55AA;
    tick();
    mem_ready = 1'b0;
    chk("edge_done_stall", stall, 0);
    tick();
    nop();
    chk("edge_wb", WB_output, 2'b11);
    chk("edge_rd", readData_output, 32'h55AA);
    chk("edge_berr", bus_err, 0);
    tick();
    chk("edge_berr2", bus_err, 0);
    $display("step ready-at-limit done");

    // Reset mid-WAIT
    set_instr(2'b11, 3'b010, 32'h400, 32'h0, 5'd6);
    tick();
    chk("rw_req", mem_req, 1);
    rst_n = 1'b0;
    nop();
    #1;
    chk("rw_req_async", mem_req, 0);
    chk("rw_stall", stall, 0);
    chk("rw_addr", mem_addr, 0);
    chk("rw_wb", WB_output, 0);
    chk("rw_alu", ALUresult_output, 0);
    tick();
    rst_n = 1'b1;
    set_instr(2'b10, 3'b000, 32'h77, 32'h0, 5'd2);
    #1 chk("rw_idle_stall", stall, 0);
    tick();
    chk("rw_idle_alu", ALUresult_output, 32'h77);
    chk("rw_idle_req", mem_req, 0);
    $display("step reset mid-wait done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
